// File: rtl/iob_sim_mem_responder.sv
// Simulation memory behind an IOb-style request/response port with a fixed
// response latency and saturating read/write access counters.
module iob_sim_mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              iob_valid_i,
  input  logic [ADDR_W-1:0] iob_addr_i,
  input  logic [DATA_W-1:0] iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic              iob_ready_o,
  output logic              iob_rvalid_o,
  output logic [DATA_W-1:0] iob_rdata_o,
  output logic [CNT_W-1:0]  rd_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam int NB = DATA_W / 8;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              pend_r, pend_s;
  logic              rvalid_r, rvalid_s;
  logic [DATA_W-1:0] rdata_r;
  logic [CNT_W-1:0]  rd_cnt_r, wr_cnt_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              accept_s;
  logic              is_write_s;
  logic [ADDR_W-3:0] widx_s;
  logic              addr_lsb_unused_s;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NB-1:0]     strb
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Sub-word address bits carry no information for a word-wide memory.
  assign addr_lsb_unused_s = ^iob_addr_i[1:0];
  assign widx_s     = iob_addr_i[ADDR_W-1:2];
  assign is_write_s = (iob_wstrb_i != {NB{1'b0}});
  assign accept_s   = (state_r == IDLE) && iob_valid_i && !rst_i;

  assign iob_ready_o  = (state_r == IDLE);
  assign iob_rvalid_o = rvalid_r;
  assign iob_rdata_o  = rdata_r;
  assign rd_cnt_o     = rd_cnt_r;
  assign wr_cnt_o     = wr_cnt_r;

  // Next-state, latency countdown and response pulse generation.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    pend_s   = pend_r;
    rvalid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && (LATENCY == 0)) begin
          rvalid_s = !is_write_s;
        end else if (accept_s) begin
          state_s = WAIT;
          cnt_s   = LAT_M1;
          pend_s  = !is_write_s;
        end else begin
          pend_s = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s  = IDLE;
          rvalid_s = pend_r;
          pend_s   = 1'b0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
        pend_s  = 1'b0;
      end
    endcase
  end

  // Control state, read data capture and saturating counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      pend_r   <= 1'b0;
      rvalid_r <= 1'b0;
      rdata_r  <= {DATA_W{1'b0}};
      rd_cnt_r <= {CNT_W{1'b0}};
      wr_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      pend_r   <= pend_s;
      rvalid_r <= rvalid_s;
      // Data is frozen at acceptance and held until the next acceptance.
      if (accept_s && !is_write_s) begin
        rdata_r <= mem_r[widx_s];
      end else begin
        rdata_r <= rdata_r;
      end
      if (accept_s && !is_write_s && (rd_cnt_r != CNT_MAX)) begin
        rd_cnt_r <= rd_cnt_r + CNT_ONE;
      end else begin
        rd_cnt_r <= rd_cnt_r;
      end
      if (accept_s && is_write_s && (wr_cnt_r != CNT_MAX)) begin
        wr_cnt_r <= wr_cnt_r + CNT_ONE;
      end else begin
        wr_cnt_r <= wr_cnt_r;
      end
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept_s && is_write_s) begin
      mem_r[widx_s] <= merge_bytes(mem_r[widx_s], iob_wdata_i, iob_wstrb_i);
    end
  end

endmodule

// File: tb/tb_iob_sim_mem_responder.sv
// Directed bench: three responder instances (LATENCY 2, 0 and 5 with 4-bit
// counters) driven from per-instance request signals.
module tb_iob_sim_mem_responder;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       vld;
  logic [2:0][11:0] addr;
  logic [2:0][31:0] wd;
  logic [2:0][3:0]  ws;
  logic [2:0]       rdy;
  logic [2:0]       rv;
  logic [2:0][31:0] rdt;
  logic [1:0][15:0] rc;
  logic [1:0][15:0] wc;
  logic [3:0]       rc2;
  logic [3:0]       wc2;

  int n_checks = 0;
  int n_err = 0;
  vec_t vecs [16];

  iob_sim_mem_responder #(.ADDR_W(12), .DATA_W(32), .LATENCY(2), .CNT_W(16)) u_l2 (
    .clk_i(clk), .rst_i(rst[0]), .iob_valid_i(vld[0]), .iob_addr_i(addr[0]),
    .iob_wdata_i(wd[0]), .iob_wstrb_i(ws[0]), .iob_ready_o(rdy[0]),
    .iob_rvalid_o(rv[0]), .iob_rdata_o(rdt[0]), .rd_cnt_o(rc[0]), .wr_cnt_o(wc[0]));

  iob_sim_mem_responder #(.ADDR_W(12), .DATA_W(32), .LATENCY(0), .CNT_W(16)) u_l0 (
    .clk_i(clk), .rst_i(rst[1]), .iob_valid_i(vld[1]), .iob_addr_i(addr[1]),
    .iob_wdata_i(wd[1]), .iob_wstrb_i(ws[1]), .iob_ready_o(rdy[1]),
    .iob_rvalid_o(rv[1]), .iob_rdata_o(rdt[1]), .rd_cnt_o(rc[1]), .wr_cnt_o(wc[1]));

  iob_sim_mem_responder #(.ADDR_W(12), .DATA_W(32), .LATENCY(5), .CNT_W(4)) u_l5 (
    .clk_i(clk), .rst_i(rst[2]), .iob_valid_i(vld[2]), .iob_addr_i(addr[2]),
    .iob_wdata_i(wd[2]), .iob_wstrb_i(ws[2]), .iob_ready_o(rdy[2]),
    .iob_rvalid_o(rv[2]), .iob_rdata_o(rdt[2]), .rd_cnt_o(rc2), .wr_cnt_o(wc2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One request on instance k; measures rvalid arrival relative to acceptance.
  task automatic xact(input int k, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp, input int lat);
    int g;
    int first;
    int pulses;
    @(negedge clk);
    vld[k] = 1'b1;
    addr[k] = a[11:0];
    wd[k] = d;
    ws[k] = s;
    g = 0;
    while (!rdy[k] && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("accept", {31'd0, rdy[k]}, 32'd1);
    @(negedge clk);
    vld[k] = 1'b0;
    ws[k] = 4'd0;
    first = 0;
    pulses = 0;
    for (int c = 1; c <= lat + 3; c++) begin
      if (c > 1) @(negedge clk);
      if (rv[k]) begin
        pulses++;
        if (first == 0) begin
          first = c;
          if (s == 4'd0) check("rdata", rdt[k], exp);
        end
      end
      if (c == 1 && lat > 0) check("ready_low_in_wait", {31'd0, rdy[k]}, 32'd0);
    end
    if (s == 4'd0) begin
      check("rvalid_cycle", first, lat + 1);
      check("rvalid_pulses", pulses, 32'd1);
    end else begin
      check("write_no_rvalid", pulses, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 3'b111;
    vld = 3'b000;
    addr = '0;
    wd = '0;
    ws = '0;

    vecs[0]  = '{16'h0000, 32'h0000_0000, 4'hF, 32'h0};
    vecs[1]  = '{16'h0004, 32'h0000_000C, 4'hF, 32'h0};
    vecs[2]  = '{16'h0008, 32'h0000_0018, 4'hF, 32'h0};
    vecs[3]  = '{16'h000C, 32'h0000_0024, 4'hF, 32'h0};
    vecs[4]  = '{16'h0010, 32'h0000_0030, 4'hF, 32'h0};
    vecs[5]  = '{16'h0000, 32'h0, 4'h0, 32'h0000_0000};
    vecs[6]  = '{16'h0004, 32'h0, 4'h0, 32'h0000_000C};
    vecs[7]  = '{16'h0008, 32'h0, 4'h0, 32'h0000_0018};
    vecs[8]  = '{16'h000C, 32'h0, 4'h0, 32'h0000_0024};
    vecs[9]  = '{16'h0010, 32'h0, 4'h0, 32'h0000_0030};
    vecs[10] = '{16'h0020, 32'hAABB_CCDD, 4'hF, 32'h0};
    vecs[11] = '{16'h0020, 32'h1122_3344, 4'h5, 32'h0};
    vecs[12] = '{16'h0020, 32'h0, 4'h0, 32'hAA22_CC44};
    vecs[13] = '{16'h1004, 32'h5A5A_5A5A, 4'hF, 32'h0};
    vecs[14] = '{16'h0004, 32'h0, 4'h0, 32'h5A5A_5A5A};
    vecs[15] = '{16'h0006, 32'h0, 4'h0, 32'h5A5A_5A5A};

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_rvalid", {31'd0, rv[k]}, 32'd0);
      check("rst_rdata", rdt[k], 32'd0);
    end
    check("rst_rd_cnt0", {16'd0, rc[0]}, 32'd0);
    check("rst_wr_cnt1", {16'd0, wc[1]}, 32'd0);
    check("rst_rd_cnt2", {28'd0, rc2}, 32'd0);
    rst = 3'b000;
    @(negedge clk);
    check("ready_after_rst", {29'd0, rdy}, 32'd7);

    // LATENCY=2 vector table
    for (int i = 0; i < 16; i++) begin
      xact(0, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].e, 2);
      if (i == 9) begin
        check("seq_wr_cnt", {16'd0, wc[0]}, 32'd5);
        check("seq_rd_cnt", {16'd0, rc[0]}, 32'd5);
      end
    end
    check("final_wr_cnt0", {16'd0, wc[0]}, 32'd8);
    check("final_rd_cnt0", {16'd0, rc[0]}, 32'd8);

    // LATENCY=0 streaming reads with valid held high
    for (int i = 0; i < 4; i++) begin
      xact(1, 16'(4 * i), 32'h1000 + 32'(i), 4'hF, 32'h0, 0);
    end
    @(negedge clk);
    vld[1] = 1'b1;
    ws[1] = 4'd0;
    addr[1] = 12'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream_ready", {31'd0, rdy[1]}, 32'd1);
      check("stream_rvalid", {31'd0, rv[1]}, 32'd1);
      check("stream_rdata", rdt[1], 32'h1000 + 32'(i));
      if (i < 3) addr[1] = 12'(4 * (i + 1));
      else vld[1] = 1'b0;
    end
    @(negedge clk);
    check("stream_rvalid_end", {31'd0, rv[1]}, 32'd0);
    check("stream_rd_cnt", {16'd0, rc[1]}, 32'd4);
    check("stream_wr_cnt", {16'd0, wc[1]}, 32'd4);

    // LATENCY=5: reset during WAIT aborts the read, keeps the earlier write
    xact(2, 16'h0008, 32'h0000_0077, 4'hF, 32'h0, 5);
    check("l5_wr_cnt", {28'd0, wc2}, 32'd1);
    @(negedge clk);
    vld[2] = 1'b1;
    addr[2] = 12'h008;
    ws[2] = 4'd0;
    @(negedge clk);
    vld[2] = 1'b0;
    check("l5_rd_cnt_pre", {28'd0, rc2}, 32'd1);
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    check("abort_rvalid", {31'd0, rv[2]}, 32'd0);
    check("abort_rd_cnt", {28'd0, rc2}, 32'd0);
    check("abort_wr_cnt", {28'd0, wc2}, 32'd0);
    rst[2] = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, rdy[2]}, 32'd1);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (rv[2]) pulses++;
      @(negedge clk);
    end
    check("abort_no_rvalid", pulses, 32'd0);

    // Saturation of the 4-bit read counter
    for (int i = 0; i < 20; i++) begin
      xact(2, 16'h0008, 32'h0, 4'h0, 32'h0000_0077, 5);
      if (i == 13) check("sat_rd_cnt_14", {28'd0, rc2}, 32'd14);
    end
    check("sat_rd_cnt", {28'd0, rc2}, 32'd15);
    check("sat_wr_cnt", {28'd0, wc2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
